// File: rtl/controlador_separador_pkg.sv
// Shared definitions for the six-digit LSB separator sequencing controller.
// Holds the controller state encoding, the digit count and width, and a
// small helper that recognises the last digit/bit slot.
package controlador_separador_pkg;

    localparam int DATA_W = 4;   // digit width, matches the separator
    localparam int N_DIG  = 6;   // number of digit slots
    localparam int IDX_W  = 3;   // wide enough to index N_DIG slots

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LATCH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // True when idx addresses the final slot (digit 5 / bit 5).
    function automatic logic is_last(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(N_DIG - 1);
    endfunction

endpackage

// File: rtl/controlador_separador_if.sv
// Digit-load handshake between a digit source and the controller.
//   start      : request a new load sequence
//   din        : digit data
//   din_valid  : din holds a digit
//   din_ready  : controller accepts din this cycle
// The master modport is the digit source, the slave modport the controller.
interface controlador_separador_if;
    import controlador_separador_pkg::*;

    logic              start;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (
        output start,
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  start,
        input  din,
        input  din_valid,
        output din_ready
    );

endinterface

// File: rtl/controlador_separador_prescaler_tick.sv
// Free-running divider used to pace the serial output.
//   clk, rst : clock and synchronous active-high reset
//   clr      : return the count to 0
//   en       : advance the count this cycle
//   tick     : high during the enabled cycle in which the count is TICK_DIV-1
// The first tick after a clear therefore lands TICK_DIV enabled cycles later.
module prescaler_tick #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] CNT_TOP = 8'(TICK_DIV - 1);

    logic [7:0] cnt;

    assign tick = en && (cnt == CNT_TOP);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/controlador_separador.sv
// Sequencing controller for the six-digit LSB separator datapath.
// Collects six digits over the bus handshake into registers m0..m5, latches
// the separator's answer s_in into bits_out, then replays bits_out s0 first
// as one-cycle strobes paced by TICK_DIV.
//   clk, rst      : clock and synchronous active-high reset
//   bus (slave)   : start / din / din_valid / din_ready
//   m0..m5        : registered digit slots feeding the separator
//   s_in          : separator outputs {s5..s0}, combinational from m0..m5
//   bits_out      : captured pattern, bit i = s_i
//   bit_serial    : current serial bit, held between strobes
//   serial_valid  : one-cycle strobe qualifying bit_serial
//   busy          : high in LOAD, LATCH and SHIFT
//   done          : high in DONE
module controlador_separador #(
    parameter int TICK_DIV = 4,
    parameter int DATA_W   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    controlador_separador_if.slave                 bus,
    output logic [DATA_W-1:0]                      m0,
    output logic [DATA_W-1:0]                      m1,
    output logic [DATA_W-1:0]                      m2,
    output logic [DATA_W-1:0]                      m3,
    output logic [DATA_W-1:0]                      m4,
    output logic [DATA_W-1:0]                      m5,
    input  logic [controlador_separador_pkg::N_DIG-1:0] s_in,
    output logic [controlador_separador_pkg::N_DIG-1:0] bits_out,
    output logic                                   bit_serial,
    output logic                                   serial_valid,
    output logic                                   busy,
    output logic                                   done
);
    import controlador_separador_pkg::*;

    state_t            state;
    logic [DATA_W-1:0] m_bank [N_DIG];
    logic [IDX_W-1:0]  dig_idx;
    logic [IDX_W-1:0]  bit_idx;
    logic              shift_en;
    logic              shift_clr;
    logic              tick;

    // The prescaler only runs in SHIFT; leaving SHIFT (and LATCH before it)
    // holds it at 0 so every replay starts with a full TICK_DIV interval.
    assign shift_en  = (state == SHIFT);
    assign shift_clr = (state != SHIFT);

    prescaler_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (shift_clr),
        .en   (shift_en),
        .tick (tick)
    );

    assign bus.din_ready = (state == LOAD);
    assign busy          = (state == LOAD) || (state == LATCH) || (state == SHIFT);
    assign done          = (state == DONE);

    assign m0 = m_bank[0];
    assign m1 = m_bank[1];
    assign m2 = m_bank[2];
    assign m3 = m_bank[3];
    assign m4 = m_bank[4];
    assign m5 = m_bank[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dig_idx      <= '0;
            bit_idx      <= '0;
            bits_out     <= '0;
            bit_serial   <= 1'b0;
            serial_valid <= 1'b0;
            for (int i = 0; i < N_DIG; i++) begin
                m_bank[i] <= '0;
            end
        end else begin
            serial_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= LOAD;
                        dig_idx <= '0;
                    end
                end
                LOAD: begin
                    if (bus.din_valid) begin
                        m_bank[dig_idx] <= bus.din;
                        if (is_last(dig_idx)) begin
                            state <= LATCH;
                        end else begin
                            dig_idx <= dig_idx + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    // m0..m5 already hold the final digit, so s_in is settled.
                    bits_out <= s_in;
                    bit_idx  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        serial_valid <= 1'b1;
                        bit_serial   <= bits_out[bit_idx];
                        if (is_last(bit_idx)) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Slots are not cleared; the next load overwrites them.
                    if (bus.start) begin
                        state   <= LOAD;
                        dig_idx <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_separador.sv
// Bench for controlador_separador: one instance with TICK_DIV=4 (A) and one
// with TICK_DIV=1 (B) share clock, reset and digit stimulus. Each has an LSB
// separator model feeding s_in back. Expected serial bits go into per-instance
// queues when digits are driven and are popped when serial_valid appears.
module tb_controlador_separador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;

    logic q_a[$];
    logic q_b[$];
    int   strobe_a[$];
    int   strobe_b[$];
    logic e_a, e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    controlador_separador_if bus_a ();
    controlador_separador_if bus_b ();

    assign bus_a.start = start;
    assign bus_a.din = din;
    assign bus_a.din_valid = din_valid;
    assign bus_b.start = start;
    assign bus_b.din = din;
    assign bus_b.din_valid = din_valid;

    logic [3:0] ma [6];
    logic [3:0] mb [6];
    logic [5:0] s_a, s_b, bo_a, bo_b;
    logic       bs_a, bs_b, sv_a, sv_b, busy_a, busy_b, done_a, done_b;

    // LSB separator models
    assign s_a = {ma[5][0], ma[4][0], ma[3][0], ma[2][0], ma[1][0], ma[0][0]};
    assign s_b = {mb[5][0], mb[4][0], mb[3][0], mb[2][0], mb[1][0], mb[0][0]};

    controlador_separador #(.TICK_DIV(4), .DATA_W(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .m0(ma[0]), .m1(ma[1]), .m2(ma[2]), .m3(ma[3]), .m4(ma[4]), .m5(ma[5]),
        .s_in(s_a), .bits_out(bo_a), .bit_serial(bs_a), .serial_valid(sv_a),
        .busy(busy_a), .done(done_a)
    );

    controlador_separador #(.TICK_DIV(1), .DATA_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .m0(mb[0]), .m1(mb[1]), .m2(mb[2]), .m3(mb[3]), .m4(mb[4]), .m5(mb[5]),
        .s_in(s_b), .bits_out(bo_b), .bit_serial(bs_b), .serial_valid(sv_b),
        .busy(busy_b), .done(done_b)
    );

    always @(negedge clk) begin
        if (!rst && sv_a) begin
            strobe_a.push_back(cyc);
            n_vec++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL serial_a_extra: got strobe with bit %b, required no strobe", bs_a);
            end else begin
                e_a = q_a.pop_front();
                if (bs_a !== e_a) begin
                    n_bad++;
                    $display("FAIL serial_a_bit: got %b required %b", bs_a, e_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sv_b) begin
            strobe_b.push_back(cyc);
            n_vec++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL serial_b_extra: got strobe with bit %b, required no strobe", bs_b);
            end else begin
                e_b = q_b.pop_front();
                if (bs_b !== e_b) begin
                    n_bad++;
                    $display("FAIL serial_b_bit: got %b required %b", bs_b, e_b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_a.delete(); q_b.delete(); strobe_a.delete(); strobe_b.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d, input int gap);
        repeat (gap) begin
            @(negedge clk); din_valid = 1'b0;
        end
        @(negedge clk);
        din = d; din_valid = 1'b1;
        n_vec++;
        if (bus_a.din_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL din_ready_load: got %b required 1", bus_a.din_ready);
        end
        q_a.push_back(d[0]);
        q_b.push_back(d[0]);
        @(posedge clk); #1 last_acc = cyc;
    endtask

    task automatic wait_done(input bit sel, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel ? done_b : done_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL done_timeout_%0d: got done=0 after %0d cycles, required 1", sel, limit);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        din = 4'hF; din_valid = 1'b1;   // ignored while idle
        repeat (20) @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (ma[i] !== 4'h0) begin
                n_bad++; $display("FAIL reset_m%0d: got %h required 0", i, ma[i]);
            end
        end
        n_vec++; if (bo_a !== 6'h0) begin n_bad++; $display("FAIL reset_bits_out: got %b required 000000", bo_a); end
        n_vec++; if (bs_a !== 1'b0) begin n_bad++; $display("FAIL reset_bit_serial: got %b required 0", bs_a); end
        n_vec++; if (sv_a !== 1'b0) begin n_bad++; $display("FAIL reset_serial_valid: got %b required 0", sv_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done_a); end
        n_vec++; if (bus_a.din_ready !== 1'b0) begin n_bad++; $display("FAIL reset_din_ready: got %b required 0", bus_a.din_ready); end
    endtask

    task automatic test_basic();
        logic [3:0] dig [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        do_reset();
        pulse_start();
        n_vec++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b required 1", busy_a); end
        for (int i = 0; i < 6; i++) send_digit(dig[i], 0);
        @(negedge clk); din_valid = 1'b0;
        wait_done(1'b0, 100);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (ma[i] !== dig[i]) begin n_bad++; $display("FAIL basic_m%0d: got %h required %h", i, ma[i], dig[i]); end
        end
        n_vec++; if (bo_a !== 6'b010101) begin n_bad++; $display("FAIL basic_bits_out: got %b required 010101", bo_a); end
        n_vec++; if (bs_a !== 1'b0) begin n_bad++; $display("FAIL basic_bit_hold: got %b required 0", bs_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b required 0", busy_a); end
        n_vec++;
        if (strobe_a.size() != 6) begin
            n_bad++; $display("FAIL basic_strobe_count: got %0d required 6", strobe_a.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (strobe_a[i] != last_acc + 5 + 4 * i) begin
                    n_bad++; $display("FAIL basic_strobe_time%0d: got cycle %0d required %0d", i, strobe_a[i], last_acc + 5 + 4 * i);
                end
            end
        end
    endtask

    task automatic test_done_restart();
        logic [3:0] dig [6] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h3};
        strobe_a.delete(); q_a.delete();
        pulse_start();
        n_vec++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin n_bad++; $display("FAIL restart_state: got done=%b busy=%b required done=0 busy=1", done_a, busy_a); end
        for (int i = 0; i < 6; i++) send_digit(dig[i], 0);
        @(negedge clk); din_valid = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();   // in SHIFT: must be ignored
        wait_done(1'b0, 100);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (ma[i] !== dig[i]) begin n_bad++; $display("FAIL restart_m%0d: got %h required %h", i, ma[i], dig[i]); end
        end
        n_vec++; if (bo_a !== 6'b100000) begin n_bad++; $display("FAIL restart_bits_out: got %b required 100000", bo_a); end
        n_vec++; if (strobe_a.size() != 6) begin n_bad++; $display("FAIL restart_strobe_count: got %0d required 6", strobe_a.size()); end
        n_vec++; if (bs_a !== 1'b1) begin n_bad++; $display("FAIL restart_bit_hold: got %b required 1", bs_a); end
    endtask

    task automatic test_gaps();
        logic [3:0] dig [6] = '{4'h9, 4'h8, 4'hF, 4'h0, 4'h7, 4'hE};
        int gap [6] = '{0, 1, 2, 3, 0, 2};
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) send_digit(dig[i], gap[i]);
        repeat (3) @(negedge clk);
        din = 4'h5;      // held valid through LATCH and into SHIFT
        repeat (4) @(negedge clk);
        din_valid = 1'b0;
        wait_done(1'b0, 100);
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (ma[i] !== dig[i]) begin n_bad++; $display("FAIL gaps_m%0d: got %h required %h", i, ma[i], dig[i]); end
        end
        n_vec++; if (bo_a !== 6'b010101) begin n_bad++; $display("FAIL gaps_bits_out: got %b required 010101", bo_a); end
        n_vec++; if (q_a.size() != 0) begin n_bad++; $display("FAIL gaps_pending: got %0d bits left required 0", q_a.size()); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] dig [6] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send_digit(4'hA + 4'(i), 0);
        @(negedge clk); din_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        q_a.delete(); q_b.delete();
        n_vec++; if (busy_a !== 1'b0 || bus_a.din_ready !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got busy=%b din_ready=%b required 0 0", busy_a, bus_a.din_ready); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (ma[i] !== 4'h0) begin n_bad++; $display("FAIL mid_m%0d_cleared: got %h required 0", i, ma[i]); end
        end
        pulse_start();
        for (int i = 0; i < 6; i++) send_digit(dig[i], 0);
        @(negedge clk); din_valid = 1'b0;
        wait_done(1'b0, 100);
        n_vec++; if (bo_a !== 6'b101010) begin n_bad++; $display("FAIL mid_bits_out: got %b required 101010", bo_a); end
        n_vec++; if (q_a.size() != 0) begin n_bad++; $display("FAIL mid_pending: got %0d bits left required 0", q_a.size()); end
    endtask

    task automatic test_tick1();
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) send_digit(4'hF, 0);
        @(negedge clk); din_valid = 1'b0;
        wait_done(1'b1, 50);
        n_vec++; if (bo_b !== 6'b111111) begin n_bad++; $display("FAIL tick1_bits_out: got %b required 111111", bo_b); end
        n_vec++;
        if (strobe_b.size() != 6) begin
            n_bad++; $display("FAIL tick1_strobe_count: got %0d required 6", strobe_b.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (strobe_b[i] != last_acc + 2 + i) begin
                    n_bad++; $display("FAIL tick1_strobe_time%0d: got cycle %0d required %0d", i, strobe_b[i], last_acc + 2 + i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_restart();
        test_gaps();
        test_reset_mid();
        test_tick1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
